// File: rtl/pdu_par_pkg.sv
// Shared constants, FSM state type and default map helper for the patch decoding unit.
package pdu_par_pkg;

    localparam logic [1:0]  PP_I           = 2'b00;
    // Truncated to OPCODE_BW at the point of use; all ones at any width.
    localparam logic [31:0] INVALID_OPCODE = '1;

    typedef enum logic [1:0] {IDLE, DECODE, HOLD} pdu_state_t;

    // Default placement: LQ i owns patches 2i and 2i+1.
    function automatic int unsigned default_pch(input int unsigned lq, input bit hi);
        return 2 * lq + (hi ? 1 : 0);
    endfunction

endpackage

// File: rtl/pdu_par_if.sv
// Instruction, map-write and result ports of the patch decoding unit.
interface pdu_par_if #(
    parameter int NUM_LQ     = 8,
    parameter int NUM_PCH    = 16,
    parameter int OPCODE_BW  = 4,
    parameter int LQADDR_BW  = 3,
    parameter int PCHADDR_BW = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [OPCODE_BW-1:0]            in_opcode;
    logic [NUM_LQ-1:0]               in_lqlist;
    logic [2*NUM_LQ-1:0]             in_lpplist;
    logic [NUM_LQ*OPCODE_BW-1:0]     in_oplist;
    logic [NUM_LQ*LQADDR_BW-1:0]     in_mreglist;
    logic                            map_we;
    logic [LQADDR_BW-1:0]            map_lq;
    logic [PCHADDR_BW-1:0]           map_pch0;
    logic [PCHADDR_BW-1:0]           map_pch1;
    logic                            out_valid;
    logic                            out_ready;
    logic [OPCODE_BW-1:0]            out_opcode;
    logic [NUM_PCH-1:0]              out_pch_list;
    logic [2*NUM_PCH-1:0]            out_pchpp_list0, out_pchpp_list1;
    logic [NUM_PCH*OPCODE_BW-1:0]    out_pchop_list0, out_pchop_list1;
    logic [NUM_PCH*LQADDR_BW-1:0]    out_pchmreg_list0, out_pchmreg_list1;
    logic                            out_conflict;

    modport master (
        output in_valid, in_opcode, in_lqlist, in_lpplist, in_oplist, in_mreglist,
               map_we, map_lq, map_pch0, map_pch1, out_ready,
        input  in_ready, out_valid, out_opcode, out_pch_list, out_pchpp_list0, out_pchpp_list1,
               out_pchop_list0, out_pchop_list1, out_pchmreg_list0, out_pchmreg_list1, out_conflict
    );
    modport slave (
        input  in_valid, in_opcode, in_lqlist, in_lpplist, in_oplist, in_mreglist,
               map_we, map_lq, map_pch0, map_pch1, out_ready,
        output in_ready, out_valid, out_opcode, out_pch_list, out_pchpp_list0, out_pchpp_list1,
               out_pchop_list0, out_pchop_list1, out_pchmreg_list0, out_pchmreg_list1, out_conflict
    );
endinterface

// File: rtl/pdu_par_maptbl.sv
// LQ-to-patch map: one write port, NRD combinational read ports; reads see pre-write contents.
module pdu_par_maptbl
    import pdu_par_pkg::*;
#(
    parameter int NUM_LQ     = 8,
    parameter int LQADDR_BW  = 3,
    parameter int PCHADDR_BW = 4,
    parameter int NRD        = 1
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [LQADDR_BW-1:0]              wr_lq,
    input  logic [PCHADDR_BW-1:0]             wr_pch0,
    input  logic [PCHADDR_BW-1:0]             wr_pch1,
    input  logic [NRD-1:0][LQADDR_BW-1:0]     rd_lq,
    output logic [NRD-1:0][PCHADDR_BW-1:0]    rd_pch0,
    output logic [NRD-1:0][PCHADDR_BW-1:0]    rd_pch1
);
    logic [NUM_LQ-1:0][PCHADDR_BW-1:0] pch0_q, pch1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LQ; i++) begin
                pch0_q[i] <= PCHADDR_BW'(default_pch(i, 1'b0));
                pch1_q[i] <= PCHADDR_BW'(default_pch(i, 1'b1));
            end
        end else if (we) begin
            pch0_q[wr_lq] <= wr_pch0;
            pch1_q[wr_lq] <= wr_pch1;
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_pch0[r] = pch0_q[rd_lq[r]];
            rd_pch1[r] = pch1_q[rd_lq[r]];
        end
    end

endmodule

// File: rtl/pdu_par.sv
// Patch decoding unit: walks set LQ bits, maps each LQ to two patches, merges per-patch lanes.
module pdu_par
    import pdu_par_pkg::*;
#(
    parameter int NUM_LQ     = 8,
    parameter int NUM_PCH    = 16,
    parameter int OPCODE_BW  = 4,
    parameter int LQADDR_BW  = 3,
    parameter int PCHADDR_BW = 4,
    parameter int LQ_PER_CYC = 1
)(
    input  logic     clk,
    input  logic     rst_n,
    pdu_par_if.slave bus
);
    localparam logic [OPCODE_BW-1:0] OP_INV = OPCODE_BW'(INVALID_OPCODE);

    pdu_state_t state, state_nxt;
    logic accept, in_ready, out_valid;

    logic [NUM_LQ-1:0]                 rem, rem_nxt;
    logic [OPCODE_BW-1:0]              opc;
    logic [NUM_LQ-1:0][1:0]            lpp;
    logic [NUM_LQ-1:0][OPCODE_BW-1:0]  lop;
    logic [NUM_LQ-1:0][LQADDR_BW-1:0]  lmreg;

    logic [NUM_PCH-1:0]                pch, pch_nxt, prior;
    logic [NUM_PCH-1:0][1:0]           pp0, pp1, pp0_n, pp1_n;
    logic [NUM_PCH-1:0][OPCODE_BW-1:0] op0, op1, op0_n, op1_n;
    logic [NUM_PCH-1:0][LQADDR_BW-1:0] mr0, mr1, mr0_n, mr1_n;
    logic                              cfl, cfl_n;
    logic [PCHADDR_BW-1:0]             tgt;

    logic [LQ_PER_CYC-1:0]                 take_v;
    logic [LQ_PER_CYC-1:0][LQADDR_BW-1:0]  take_q;
    logic [LQ_PER_CYC-1:0][PCHADDR_BW-1:0] rpch0, rpch1;

    pdu_par_maptbl #(
        .NUM_LQ(NUM_LQ), .LQADDR_BW(LQADDR_BW), .PCHADDR_BW(PCHADDR_BW), .NRD(LQ_PER_CYC)
    ) u_map (
        .clk(clk), .rst_n(rst_n), .we(bus.map_we), .wr_lq(bus.map_lq),
        .wr_pch0(bus.map_pch0), .wr_pch1(bus.map_pch1),
        .rd_lq(take_q), .rd_pch0(rpch0), .rd_pch1(rpch1)
    );

    // Successive lowest-set-bit picks; slot k always holds a higher LQ than slot k-1.
    always_comb begin
        rem_nxt = rem;
        take_v  = '0;
        take_q  = '0;
        for (int k = 0; k < LQ_PER_CYC; k++) begin
            for (int i = NUM_LQ - 1; i >= 0; i--) begin
                if (rem_nxt[i]) begin
                    take_v[k] = 1'b1;
                    take_q[k] = LQADDR_BW'(i);
                end
            end
            if (take_v[k]) rem_nxt[take_q[k]] = 1'b0;
        end
    end

    // Later slots overwrite earlier ones, so the higher-indexed LQ wins a shared patch.
    always_comb begin
        pch_nxt = pch;
        pp0_n = pp0;  pp1_n = pp1;
        op0_n = op0;  op1_n = op1;
        mr0_n = mr0;  mr1_n = mr1;
        cfl_n = cfl;
        prior = '0;
        tgt   = '0;
        for (int k = 0; k < LQ_PER_CYC; k++) begin
            prior = pch_nxt;
            for (int h = 0; h < 2; h++) begin
                tgt = (h == 0) ? rpch0[k] : rpch1[k];
                if (state == DECODE && take_v[k]) begin
                    if (prior[tgt]) cfl_n = 1'b1;
                    pch_nxt[tgt] = 1'b1;
                    if (!take_q[k][0]) begin
                        pp0_n[tgt] = lpp[take_q[k]];
                        op0_n[tgt] = lop[take_q[k]];
                        mr0_n[tgt] = lmreg[take_q[k]];
                        pp1_n[tgt] = PP_I;
                        op1_n[tgt] = OP_INV;
                        mr1_n[tgt] = '0;
                    end else begin
                        pp1_n[tgt] = lpp[take_q[k]];
                        op1_n[tgt] = lop[take_q[k]];
                        mr1_n[tgt] = lmreg[take_q[k]];
                        pp0_n[tgt] = PP_I;
                        op0_n[tgt] = OP_INV;
                        mr0_n[tgt] = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:   in_ready = 1'b1;
            DECODE: if (rem_nxt == '0) state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = bus.in_valid & in_ready;
        if (accept) state_nxt = (bus.in_lqlist != '0) ? DECODE : HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            opc   <= OP_INV;
            lpp   <= '0;
            lop   <= '0;
            lmreg <= '0;
            pch   <= '0;
            pp0   <= {NUM_PCH{PP_I}};
            pp1   <= {NUM_PCH{PP_I}};
            op0   <= {NUM_PCH{OP_INV}};
            op1   <= {NUM_PCH{OP_INV}};
            mr0   <= '0;
            mr1   <= '0;
            cfl   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opc   <= bus.in_opcode;
                rem   <= bus.in_lqlist;
                lpp   <= bus.in_lpplist;
                lop   <= bus.in_oplist;
                lmreg <= bus.in_mreglist;
                pch   <= '0;
                pp0   <= {NUM_PCH{PP_I}};
                pp1   <= {NUM_PCH{PP_I}};
                op0   <= {NUM_PCH{OP_INV}};
                op1   <= {NUM_PCH{OP_INV}};
                mr0   <= '0;
                mr1   <= '0;
                cfl   <= 1'b0;
            end else if (state == DECODE) begin
                rem <= rem_nxt;
                pch <= pch_nxt;
                pp0 <= pp0_n;
                pp1 <= pp1_n;
                op0 <= op0_n;
                op1 <= op1_n;
                mr0 <= mr0_n;
                mr1 <= mr1_n;
                cfl <= cfl_n;
            end
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = out_valid;
    assign bus.out_opcode        = opc;
    assign bus.out_pch_list      = pch;
    assign bus.out_pchpp_list0   = pp0;
    assign bus.out_pchpp_list1   = pp1;
    assign bus.out_pchop_list0   = op0;
    assign bus.out_pchop_list1   = op1;
    assign bus.out_pchmreg_list0 = mr0;
    assign bus.out_pchmreg_list1 = mr1;
    assign bus.out_conflict      = cfl;

endmodule

// File: tb/tb_pdu_par.sv
// Directed bench: one-LQ-per-cycle and two-LQ-per-cycle units share the same stimulus.
module tb_pdu_par;
    import pdu_par_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    pdu_par_if if1 ();
    pdu_par_if if2 ();

    assign if2.in_valid    = if1.in_valid;
    assign if2.in_opcode   = if1.in_opcode;
    assign if2.in_lqlist   = if1.in_lqlist;
    assign if2.in_lpplist  = if1.in_lpplist;
    assign if2.in_oplist   = if1.in_oplist;
    assign if2.in_mreglist = if1.in_mreglist;
    assign if2.map_we      = if1.map_we;
    assign if2.map_lq      = if1.map_lq;
    assign if2.map_pch0    = if1.map_pch0;
    assign if2.map_pch1    = if1.map_pch1;
    assign if2.out_ready   = if1.out_ready;

    pdu_par #(.LQ_PER_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    pdu_par #(.LQ_PER_CYC(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] opc, input logic [7:0] lq, input logic [15:0] pp,
                        input logic [31:0] op, input logic [23:0] mr);
        if1.in_valid    = 1'b1;
        if1.in_opcode   = opc;
        if1.in_lqlist   = lq;
        if1.in_lpplist  = pp;
        if1.in_oplist   = op;
        if1.in_mreglist = mr;
    endtask

    // Instruction A: LQ0 pp=X op=5 mreg=2, LQ1 pp=Z op=6 mreg=5, opcode 3.
    task automatic send_a();
        send(4'h3, 8'b0000_0011, 16'h0009, 32'h0000_0065, 24'h00002A);
    endtask

    initial begin
        // Reset held with random inputs
        rst_n = 1'b0;
        if1.in_valid    = 1'($urandom);
        if1.in_opcode   = 4'($urandom);
        if1.in_lqlist   = 8'($urandom);
        if1.in_lpplist  = 16'($urandom);
        if1.in_oplist   = $urandom;
        if1.in_mreglist = 24'($urandom);
        if1.map_we      = 1'b1;
        if1.map_lq      = 3'($urandom);
        if1.map_pch0    = 4'($urandom);
        if1.map_pch1    = 4'($urandom);
        if1.out_ready   = 1'($urandom);
        tick(); tick();
        chk("rst_out_valid", 64'(if1.out_valid), 64'h0);
        chk("rst_in_ready", 64'(if1.in_ready), 64'h1);
        chk("rst_pch_list", 64'(if1.out_pch_list), 64'h0);
        chk("rst_opcode", 64'(if1.out_opcode), 64'hF);
        chk("rst_op0", if1.out_pchop_list0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_op1", if1.out_pchop_list1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_pp0", 64'(if1.out_pchpp_list0), 64'h0);
        chk("rst_conflict", 64'(if1.out_conflict), 64'h0);
        chk("rst_map_lq3", 64'(dut1.u_map.pch1_q[3]), 64'h7);

        if1.in_valid = 1'b0;
        if1.map_we   = 1'b0;
        if1.out_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        // Two LQs, default map: latency 2 (one per cycle) vs 1 (two per cycle)
        send_a();
        tick();
        if1.in_valid = 1'b0;
        chk("a_lat0_u1", 64'(if1.out_valid), 64'h0);
        chk("a_lat0_u2", 64'(if2.out_valid), 64'h0);
        chk("a_busy_ready", 64'(if1.in_ready), 64'h0);
        tick();
        chk("a_lat1_u1", 64'(if1.out_valid), 64'h0);
        chk("a_lat1_u2", 64'(if2.out_valid), 64'h1);
        tick();
        chk("a_lat2_u1", 64'(if1.out_valid), 64'h1);
        chk("a_opcode", 64'(if1.out_opcode), 64'h3);
        chk("a_pch", 64'(if1.out_pch_list), 64'h000F);
        chk("a_pp0", 64'(if1.out_pchpp_list0), 64'h5);
        chk("a_pp1", 64'(if1.out_pchpp_list1), 64'hA0);
        chk("a_op0", if1.out_pchop_list0, 64'hFFFF_FFFF_FFFF_FF55);
        chk("a_op1", if1.out_pchop_list1, 64'hFFFF_FFFF_FFFF_66FF);
        chk("a_mr0", 64'(if1.out_pchmreg_list0), 64'h12);
        chk("a_mr1", 64'(if1.out_pchmreg_list1), 64'hB40);
        chk("a_conflict", 64'(if1.out_conflict), 64'h0);
        chk("a2_pch", 64'(if2.out_pch_list), 64'h000F);
        chk("a2_pp1", 64'(if2.out_pchpp_list1), 64'hA0);
        chk("a2_op0", if2.out_pchop_list0, 64'hFFFF_FFFF_FFFF_FF55);
        chk("a2_mr1", 64'(if2.out_pchmreg_list1), 64'hB40);
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;
        chk("a_drained", 64'(if1.out_valid), 64'h0);

        // Backpressure: B (LQ2) held while empty instruction C waits
        send(4'h7, 8'b0000_0100, 16'h0030, 32'h0000_0900, 24'h0001C0);
        tick();
        send(4'h1, 8'h00, 16'hFFFF, 32'hFFFF_FFFF, 24'hFFFFFF);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(if1.out_valid), 64'h1);
            chk("bp_in_ready", 64'(if1.in_ready), 64'h0);
            chk("bp_pch", 64'(if1.out_pch_list), 64'h0030);
            chk("bp_pp0", 64'(if1.out_pchpp_list0), 64'hF00);
            tick();
        end
        chk("b_opcode", 64'(if1.out_opcode), 64'h7);
        chk("b_op0", if1.out_pchop_list0, 64'hFFFF_FFFF_FF99_FFFF);
        chk("b_mr0", 64'(if1.out_pchmreg_list0), 64'h3F000);
        if1.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(if1.in_ready), 64'h1);
        tick();
        if1.in_valid = 1'b0;
        chk("c_valid", 64'(if1.out_valid), 64'h1);
        chk("c_opcode", 64'(if1.out_opcode), 64'h1);
        chk("c_pch", 64'(if1.out_pch_list), 64'h0);
        chk("c_pp0", 64'(if1.out_pchpp_list0), 64'h0);
        chk("c_op1", if1.out_pchop_list1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        if1.out_ready = 1'b0;
        chk("c_drained", 64'(if1.out_valid), 64'h0);

        // Remap LQ1 onto patches 0/1, then A again: conflict, LQ1 wins
        if1.map_we   = 1'b1;
        if1.map_lq   = 3'd1;
        if1.map_pch0 = 4'd0;
        if1.map_pch1 = 4'd1;
        tick();
        if1.map_we = 1'b0;
        send_a();
        tick();
        if1.in_valid = 1'b0;
        tick(); tick();
        chk("m_valid", 64'(if1.out_valid), 64'h1);
        chk("m_pch", 64'(if1.out_pch_list), 64'h0003);
        chk("m_conflict", 64'(if1.out_conflict), 64'h1);
        chk("m_pp0", 64'(if1.out_pchpp_list0), 64'h0);
        chk("m_pp1", 64'(if1.out_pchpp_list1), 64'hA);
        chk("m_op0", if1.out_pchop_list0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("m_op1", if1.out_pchop_list1, 64'hFFFF_FFFF_FFFF_FF66);
        chk("m_mr0", 64'(if1.out_pchmreg_list0), 64'h0);
        chk("m_mr1", 64'(if1.out_pchmreg_list1), 64'h2D);
        chk("m2_conflict", 64'(if2.out_conflict), 64'h1);
        chk("m2_pch", 64'(if2.out_pch_list), 64'h0003);
        chk("m2_op1", if2.out_pchop_list1, 64'hFFFF_FFFF_FFFF_FF66);
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;

        // Reset during the second DECODE cycle of an 8-LQ instruction
        send(4'h2, 8'hFF, 16'h0, 32'h0, 24'h0);
        tick();
        if1.in_valid = 1'b0;
        tick();
        chk("d_busy", 64'(if1.in_ready), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(if1.out_valid), 64'h0);
        chk("mrst_in_ready", 64'(if1.in_ready), 64'h1);
        chk("mrst_pch", 64'(if1.out_pch_list), 64'h0);
        chk("mrst_opcode", 64'(if1.out_opcode), 64'hF);
        chk("mrst_map_pch0", 64'(dut1.u_map.pch0_q[1]), 64'h2);
        chk("mrst_map_pch1", 64'(dut1.u_map.pch1_q[1]), 64'h3);
        tick();
        rst_n = 1'b1;
        tick();

        // Default map is back in effect
        send_a();
        tick();
        if1.in_valid = 1'b0;
        tick(); tick();
        chk("r_valid", 64'(if1.out_valid), 64'h1);
        chk("r_pch", 64'(if1.out_pch_list), 64'h000F);
        chk("r_conflict", 64'(if1.out_conflict), 64'h0);
        chk("r_pp1", 64'(if1.out_pchpp_list1), 64'hA0);
        if1.out_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
